// File: rtl/systolic_array_os.sv
// systolic_array_os: output-stationary ROWS x COLS MAC array, C = A * B with runtime K.
// Optional SYSTOLIC_SAT_EN: saturating accumulators driving a sticky ovf flag.
module systolic_array_os #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int K_WIDTH    = 10,
    parameter int SIGNED     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [K_WIDTH-1:0]                    k_len,
    output logic                                  busy,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]            a_col,
    input  logic [COLS*DATA_WIDTH-1:0]            b_row,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [COLS*ACC_WIDTH-1:0]             out_data,
    output logic [((ROWS>1)?$clog2(ROWS):1)-1:0]  out_row,
    output logic                                  out_last,
    output logic                                  ovf
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FL_N  = ROWS + COLS - 1;
    localparam int FL_W  = (FL_N > 1) ? $clog2(FL_N) : 1;
    localparam int AW1   = ACC_WIDTH + 1;

    if (ACC_WIDTH < 2*DATA_WIDTH) begin : g_bad_acc
        $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [K_WIDTH-1:0]   r_klen;
    logic [K_WIDTH-1:0]   r_beat;
    logic [FL_W-1:0]      r_fcnt;
    logic [ROW_W-1:0]     r_row;

    logic                 w_start;
    logic                 w_accept;
    logic                 w_last_beat;
    logic                 w_flush_done;
    logic                 w_out_fire;
    logic                 w_drain_done;

    logic [DATA_WIDTH-1:0] w_a  [ROWS][COLS];
    logic                  w_av [ROWS][COLS];
    logic [DATA_WIDTH-1:0] w_b  [ROWS][COLS];
    logic                  w_bv [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  w_acc [ROWS][COLS];

    assign w_start      = (r_state == S_IDLE) && start;
    assign w_accept     = (r_state == S_LOAD) && in_valid;
    assign w_last_beat  = w_accept && (r_beat == r_klen - K_WIDTH'(1));
    assign w_flush_done = (r_state == S_FLUSH) && (r_fcnt == FL_W'(FL_N - 1));
    assign w_out_fire   = (r_state == S_DRAIN) && out_ready;
    assign w_drain_done = w_out_fire && (r_row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (k_len == '0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last_beat) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_done) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_klen <= '0;
            r_beat <= '0;
            r_fcnt <= '0;
            r_row  <= '0;
        end else begin
            if (w_start) begin
                r_klen <= k_len;
                r_beat <= '0;
                r_fcnt <= '0;
            end
            if (w_accept) begin
                r_beat <= r_beat + K_WIDTH'(1);
            end
            if (r_state == S_FLUSH) begin
                r_fcnt <= r_fcnt + FL_W'(1);
            end
            if (w_out_fire) begin
                r_row <= w_drain_done ? '0 : r_row + ROW_W'(1);
            end
        end
    end

    // Element 0 of each lane chain is the input register; the rest skew it.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        logic [DATA_WIDTH-1:0] r_d [0:r];
        logic                  r_v [0:r];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) begin
                    r_d[i] <= '0;
                    r_v[i] <= 1'b0;
                end
            end else begin
                r_v[0] <= w_accept;
                if (w_accept) begin
                    r_d[0] <= a_col[r*DATA_WIDTH +: DATA_WIDTH];
                end
                for (int i = 1; i <= r; i++) begin
                    r_d[i] <= r_d[i-1];
                    r_v[i] <= r_v[i-1];
                end
            end
        end
        assign w_a[r][0]  = r_d[r];
        assign w_av[r][0] = r_v[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        logic [DATA_WIDTH-1:0] r_d [0:c];
        logic                  r_v [0:c];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i <= c; i++) begin
                    r_d[i] <= '0;
                    r_v[i] <= 1'b0;
                end
            end else begin
                r_v[0] <= w_accept;
                if (w_accept) begin
                    r_d[0] <= b_row[c*DATA_WIDTH +: DATA_WIDTH];
                end
                for (int i = 1; i <= c; i++) begin
                    r_d[i] <= r_d[i-1];
                    r_v[i] <= r_v[i-1];
                end
            end
        end
        assign w_b[0][c]  = r_d[c];
        assign w_bv[0][c] = r_v[c];
    end

`ifdef SYSTOLIC_SAT_EN
    logic [ROWS*COLS-1:0] w_pe_ovf;
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c > 0) begin : g_ah
                logic [DATA_WIDTH-1:0] r_a;
                logic                  r_av;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_a  <= '0;
                        r_av <= 1'b0;
                    end else begin
                        r_a  <= w_a[r][c-1];
                        r_av <= w_av[r][c-1];
                    end
                end
                assign w_a[r][c]  = r_a;
                assign w_av[r][c] = r_av;
            end

            if (r > 0) begin : g_bv
                logic [DATA_WIDTH-1:0] r_b;
                logic                  r_bv;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_b  <= '0;
                        r_bv <= 1'b0;
                    end else begin
                        r_b  <= w_b[r-1][c];
                        r_bv <= w_bv[r-1][c];
                    end
                end
                assign w_b[r][c]  = r_b;
                assign w_bv[r][c] = r_bv;
            end

            logic [ACC_WIDTH-1:0]    r_acc;
            logic [ACC_WIDTH-1:0]    w_acc_nx;
            logic [2*DATA_WIDTH-1:0] w_ax;
            logic [2*DATA_WIDTH-1:0] w_bx;
            logic [2*DATA_WIDTH-1:0] w_prod;
            logic                    w_fire;

            assign w_fire = w_av[r][c] & w_bv[r][c];

            // Operands are pre-extended so the 2N-bit product is exact.
            always_comb begin
                if (SIGNED != 0) begin
                    w_ax = {{DATA_WIDTH{w_a[r][c][DATA_WIDTH-1]}}, w_a[r][c]};
                    w_bx = {{DATA_WIDTH{w_b[r][c][DATA_WIDTH-1]}}, w_b[r][c]};
                end else begin
                    w_ax = {{DATA_WIDTH{1'b0}}, w_a[r][c]};
                    w_bx = {{DATA_WIDTH{1'b0}}, w_b[r][c]};
                end
                w_prod = w_ax * w_bx;
            end

`ifdef SYSTOLIC_SAT_EN
            logic [ACC_WIDTH:0] w_pext;
            logic [ACC_WIDTH:0] w_aext;
            logic [ACC_WIDTH:0] w_sum;
            logic               w_sat;

            always_comb begin
                if (SIGNED != 0) begin
                    w_pext = AW1'($signed(w_prod));
                    w_aext = AW1'($signed(r_acc));
                end else begin
                    w_pext = AW1'(w_prod);
                    w_aext = {1'b0, r_acc};
                end
                w_sum = w_aext + w_pext;
                if (SIGNED != 0) begin
                    w_sat = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
                end else begin
                    w_sat = w_sum[ACC_WIDTH];
                end
                if (!w_sat) begin
                    w_acc_nx = w_sum[ACC_WIDTH-1:0];
                end else if (SIGNED == 0) begin
                    w_acc_nx = '1;
                end else begin
                    w_acc_nx = {w_sum[ACC_WIDTH],
                                {(ACC_WIDTH-1){~w_sum[ACC_WIDTH]}}};
                end
            end
            assign w_pe_ovf[r*COLS+c] = w_fire & w_sat;
`else
            logic [ACC_WIDTH-1:0] w_pext;

            always_comb begin
                if (SIGNED != 0) begin
                    w_pext = ACC_WIDTH'($signed(w_prod));
                end else begin
                    w_pext = ACC_WIDTH'(w_prod);
                end
            end
            assign w_acc_nx = r_acc + w_pext;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (w_start) begin
                    r_acc <= '0;
                end else if (w_fire) begin
                    r_acc <= w_acc_nx;
                end
            end
            assign w_acc[r][c] = r_acc;
        end
    end

`ifdef SYSTOLIC_SAT_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_ovf <= 1'b0;
        end else if (|w_pe_ovf) begin
            r_ovf <= 1'b1;
        end
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy      = (r_state != S_IDLE);
    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_DRAIN);
    assign out_row   = r_row;
    assign out_last  = (r_state == S_DRAIN) && (r_row == ROW_W'(ROWS - 1));

    always_comb begin
        out_data = '0;
        if (r_state == S_DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                out_data[c*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][c];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_os.sv
// tb_systolic_array_os: table-driven jobs with a row scoreboard, plus
// back-pressure, k_len=0, start-in-DRAIN and mid-job reset sequences.
module tb_systolic_array_os;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int KW = 10;
`ifdef SYSTOLIC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint MAXS = 64'sd8388607;
    localparam longint MINS = -64'sd8388608;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [R*DW-1:0] a_col;
    logic [C*DW-1:0] b_row;
    logic            out_valid;
    logic            out_ready;
    logic [C*AW-1:0] out_data;
    logic [1:0]      out_row;
    logic            out_last;
    logic            ovf;

    systolic_array_os #(
        .ROWS(R), .COLS(C), .DATA_WIDTH(DW),
        .ACC_WIDTH(AW), .K_WIDTH(KW), .SIGNED(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [C*AW-1:0] data;
        int              row;
        bit              ovf;
    } exp_t;

    typedef struct {
        string        name;
        int           klen;
        int           a_kind;
        int           a_val;
        int           b_kind;
        int           b_val;
        bit           bub;
        int           exp_rdy;
        bit           has_exp;
        logic [AW-1:0] exp_c00;
        logic [AW-1:0] exp_c33;
    } vec_t;

    exp_t          q[$];
    vec_t          vecs[5];
    logic [DW-1:0] ma [R][1024];
    logic [DW-1:0] mb [1024][C];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            chk_idle = 1'b0;
    logic [AW-1:0] got_c00;
    logic [AW-1:0] got_c33;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Scoreboard consumer: one entry per accepted output row.
    always @(negedge clk) begin
        exp_t e;
        if (chk_idle) begin
            chk_idle = 1'b0;
            check("idle_busy", busy, 0);
            check("idle_out_valid", out_valid, 0);
        end
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_row: row %0d, want none", out_row);
            end else begin
                e = q.pop_front();
                check($sformatf("row%0d_data", e.row), out_data, e.data);
                check($sformatf("row%0d_idx", e.row), out_row, e.row);
                check($sformatf("row%0d_last", e.row), out_last, e.row == R-1);
                check($sformatf("row%0d_ovf", e.row), ovf, e.ovf);
                if (out_row == 0) got_c00 = out_data[AW-1:0];
                if (out_row == 3) got_c33 = out_data[C*AW-1 -: AW];
                if (out_last) chk_idle = 1'b1;
            end
        end
    end

    task automatic fill_ops(input vec_t v);
        for (int k = 0; k < v.klen; k++) begin
            for (int r = 0; r < R; r++) begin
                case (v.a_kind)
                    0:       ma[r][k] = (r == k) ? 8'd1 : 8'd0;
                    1:       ma[r][k] = v.a_val[DW-1:0];
                    default: ma[r][k] = DW'($urandom_range(0, 255));
                endcase
            end
            for (int c = 0; c < C; c++) begin
                case (v.b_kind)
                    0:       mb[k][c] = DW'(4*k + c + 1);
                    1:       mb[k][c] = v.b_val[DW-1:0];
                    default: mb[k][c] = DW'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic push_expected(input int klen);
        logic [C*AW-1:0] rows [R];
        longint s;
        longint p;
        bit     o;
        exp_t   e;
        o = 1'b0;
        for (int r = 0; r < R; r++) begin
            rows[r] = '0;
            for (int c = 0; c < C; c++) begin
                s = 0;
                for (int k = 0; k < klen; k++) begin
                    p = longint'($signed(ma[r][k])) * longint'($signed(mb[k][c]));
                    s = s + p;
                    if (SAT && s > MAXS) begin
                        s = MAXS;
                        o = 1'b1;
                    end
                    if (SAT && s < MINS) begin
                        s = MINS;
                        o = 1'b1;
                    end
                end
                rows[r][c*AW +: AW] = s[AW-1:0];
            end
        end
        for (int r = 0; r < R; r++) begin
            e.data = rows[r];
            e.row  = r;
            e.ovf  = o;
            q.push_back(e);
        end
    endtask

    task automatic set_beat(input int k);
        for (int r = 0; r < R; r++) a_col[r*DW +: DW] = ma[r][k];
        for (int c = 0; c < C; c++) b_row[c*DW +: DW] = mb[k][c];
    endtask

    task automatic drive_job(input int klen, input bit bub, output int rdy);
        int  k;
        int  cyc;
        bit  acc;
        k   = 0;
        cyc = 0;
        rdy = 0;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(klen);
        @(posedge clk); #1;
        start = 1'b0;
        while (k < klen && cyc < 3*klen + 20) begin
            in_valid = bub ? (cyc % 2 == 0) : 1'b1;
            set_beat(k);
            @(negedge clk);
            if (in_ready) rdy++;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        if (k < klen) fail_now("load_beats");
        @(negedge clk);
        check("ready_drop", in_ready, 0);
    endtask

    task automatic wait_idle(input string nm);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < 2000);
        if (busy) fail_now(nm);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string nm);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_valid && g < 100);
        if (!out_valid) fail_now(nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rdy;
        int   fl;
        vec_t v;
        logic [C*AW-1:0] row1;

        vecs[0] = '{"identity", 4, 0, 0, 0, 0, 1'b0, 4, 1'b1, 24'd1, 24'd16};
        vecs[1] = '{"bubbles", 4, 1, 255, 1, 2, 1'b1, 7, 1'b1,
                    24'hFFFFF8, 24'hFFFFF8};
        vecs[2] = '{"neg_sq", 7, 1, 128, 1, 128, 1'b0, 7, 1'b1,
                    24'h01C000, 24'h01C000};
        vecs[3] = '{"overflow", 600, 1, 127, 1, 127, 1'b0, 600, 1'b1,
                    SAT ? 24'h7FFFFF : 24'h93AA58,
                    SAT ? 24'h7FFFFF : 24'h93AA58};
        vecs[4] = '{"random", 6, 2, 0, 2, 0, 1'b1, 11, 1'b0, 24'd0, 24'd0};

        rst_n     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        a_col     = '0;
        b_row     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ovf", ovf, 0);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            got_c00 = 'x;
            got_c33 = 'x;
            fill_ops(v);
            push_expected(v.klen);
            drive_job(v.klen, v.bub, rdy);
            check({v.name, "_ready_cycles"}, rdy, v.exp_rdy);
            wait_idle({v.name, "_idle"});
            if (v.has_exp) begin
                check({v.name, "_c00"}, got_c00, v.exp_c00);
                check({v.name, "_c33"}, got_c33, v.exp_c33);
            end
        end

        // Back-pressure: hold row 1 for five cycles.
        v = vecs[0];
        fill_ops(v);
        push_expected(4);
        row1 = {24'd8, 24'd7, 24'd6, 24'd5};
        out_ready = 1'b0;
        drive_job(4, 1'b0, rdy);
        wait_valid("bp_valid");
        check("bp_first_row", out_row, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_data", i), out_data, row1);
            check($sformatf("bp_hold%0d_row", i), out_row, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle("bp_idle");

        // k_len = 0 goes straight to FLUSH, then drains zeros.
        push_expected(0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        rdy = 0;
        fl  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) rdy++;
            if (out_valid) break;
            if (busy) fl++;
            @(posedge clk); #1;
        end
        check("k0_in_ready", rdy, 0);
        check("k0_flush_cycles", fl, 7);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        wait_idle("k0_idle");
        repeat (4) @(negedge clk);
        check("drain_start_ignored", busy, 0);
        @(posedge clk); #1;

        // Reset during LOAD beat 2, then a clean identity job.
        v = vecs[0];
        fill_ops(v);
        start = 1'b1;
        k_len = KW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        set_beat(0);
        @(posedge clk); #1;
        set_beat(1);
        @(posedge clk); #1;
        set_beat(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        got_c00 = 'x;
        got_c33 = 'x;
        push_expected(4);
        drive_job(4, 1'b0, rdy);
        wait_idle("post_rst_idle");
        check("post_rst_c00", got_c00, 24'd1);
        check("post_rst_c33", got_c33, 24'd16);
        check("sb_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
- Output-stationary, parametrised successor to the fixed square systolic MAC array.
- Computes C[ROWS×COLS] = A[ROWS×K] · B[K×COLS] for a runtime-programmable K.
- Skews the operand streams internally, tolerates input bubbles and output back-pressure via valid/ready handshakes, and drains results one row per beat.
- Sits between the operand-fetch buffers and the accumulator/writeback stage of the DNN accelerator datapath.

Parameters:
- ROWS, 4: PE rows (number of A rows / C rows).
- COLS, 4: PE columns (number of B columns / C columns).
- DATA_WIDTH, 8: operand width, two's complement when SIGNED=1.
- ACC_WIDTH, 2*DATA_WIDTH+8: per-PE accumulator width; must be ≥ 2*DATA_WIDTH.
- K_WIDTH, 10: width of k_len; max K = 2^K_WIDTH-1.
- SIGNED, 1: 1 = signed multiply/accumulate, 0 = unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begins a job, sampled only in IDLE
- k_len  in  K_WIDTH  reduction length, captured on accepted start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in LOAD
- a_col  in  ROWS*DATA_WIDTH  A[r][k] for all r; lane r = bits [r*DATA_WIDTH +: DATA_WIDTH]
- b_row  in  COLS*DATA_WIDTH  B[k][c] for all c; same lane packing
- out_valid  out  1  result row valid
- out_ready  in  1  result row accepted
- out_data  out  COLS*ACC_WIDTH  C[out_row][c]; lane c = bits [c*ACC_WIDTH +: ACC_WIDTH]
- out_row  out  $clog2(ROWS) (min 1)  row index of out_data
- out_last  out  1  high with out_valid on row ROWS-1
- ovf  out  1  sticky accumulator overflow flag for the current job

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE.
  - All accumulators, skew registers and lane valids clear.
  - Outputs: busy=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, ovf=0.
  - Reset mid-job aborts the job with no partial output.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
  - IDLE: start=1 with k_len≠0 clears accumulators and ovf, latches k_len, goes to LOAD.
  - IDLE: start=1 with k_len=0 clears accumulators and ovf and goes directly to FLUSH.
  - start is ignored outside IDLE.
- LOAD:
  - in_ready=1; a beat is accepted when in_valid && in_ready.
  - A beat counter runs from 0; after the k_len-th accepted beat the FSM goes to FLUSH next cycle.
  - in_valid=0 cycles insert bubbles carrying valid=0.
- Datapath:
  - Accepted beats enter an input register stage.
  - A lane r passes through r skew registers, then moves right one PE per cycle.
  - B lane c passes through c skew registers, then moves down one PE per cycle.
  - Each lane carries its own valid bit.
  - PE(r,c) sees beat k exactly r+c+1 cycles after its acceptance edge.
  - A PE accumulates acc += a*b only when its incoming valid is 1; bubbles never change the accumulator.
  - Products are full 2*DATA_WIDTH precision, sign- or zero-extended per SIGNED, then added modulo 2^ACC_WIDTH.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles, counted by a flush counter, then goes to DRAIN.
  - After FLUSH every PE holds its final value.
- DRAIN:
  - out_valid=1; out_data shows accumulator row out_row, starting at 0.
  - On out_valid && out_ready, out_row increments.
  - While out_ready=0, out_data, out_row and out_last hold stable.
  - The handshake on row ROWS-1 (out_last=1) returns the FSM to IDLE with out_valid=0 the next cycle.
- Outputs are registered or driven directly from state/accumulators; there is no combinational path from in_valid or out_ready to any output except via the state registers.
- ovf:
  - Set when any PE's true sum leaves the ACC_WIDTH range.
  - Stays set until the next accepted start or reset.
  - Without SYSTOLIC_SAT_EN, ovf is tied to 0.

Optional Feature:
- Macro: SYSTOLIC_SAT_EN.
- Defined: each PE saturates its accumulator.
  - SIGNED=1 clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SIGNED=0 clamps to [0, 2^ACC_WIDTH-1].
  - Saturation drives the sticky ovf flag.
- Undefined: wrap-around accumulation, ovf constant 0, no saturation logic synthesised.

Test Plan (ROWS=COLS=4, DATA_WIDTH=8, ACC_WIDTH=24, SIGNED=1):
1. Identity: k_len=4, A=I, B[k][c]=4k+c+1, in_valid continuous.
   - Required: 4 output rows with C=B (row0 = 1,2,3,4 … row3 = 13,14,15,16).
   - Required: out_last on row 3; busy drops the cycle after the last handshake.
2. Signed, with bubbles: k_len=4, all A=0xFF, all B=0x02, in_valid toggling 1/0.
   - Required: every C = 0xFFFFF8 (−8).
   - Required: in_ready held for 7 cycles until the 4th beat is accepted.
3. Back-pressure: test 1 with out_ready=0 for 5 cycles while out_row=1.
   - Required: out_data stays at row1 = 5,6,7,8, stable; rows delivered in order 0..3, none dropped or duplicated.
4. k_len=0 start:
   - Required: in_ready never asserts; after 7 FLUSH cycles, 4 all-zero rows.
   - Required: a start pulse during DRAIN is ignored.
5. Overflow: k_len=600, all A=B=0x7F.
   - With SYSTOLIC_SAT_EN: C=0x7FFFFF, ovf=1.
   - Without it: C=0x93AA58, ovf=0.
6. Reset mid-job: rst_n=0 for 1 cycle during LOAD beat 2.
   - Required: next cycle busy=0, out_valid=0.
   - Required: a following job using test 1 stimulus produces exact identity results, with no residue from the aborted job.
